// File: rtl/calc_core_n.sv
// calc_core_n: keypad-driven decimal calculator core with add, subtract, shift-add multiply,
// sequential double-dabble and a scanned BCD display buffer. Define CALC_DIV_EN for restoring divide.
module calc_core_n #(
  parameter int DIGITS = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [3:0]                cmd,
  input  logic                      cmd_valid,
  output logic [1:0]                status,
  output logic [3:0]                data,
  output logic [$clog2(DIGITS)-1:0] position
);
  localparam int W  = $clog2(10**DIGITS);
  localparam int PW = $clog2(DIGITS);
  localparam int CW = $clog2(W);
  localparam logic [2*W-1:0] LIMIT = (2*W)'(10**DIGITS);

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;
  localparam logic [1:0] ST_VALID = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_IN_A, S_OP, S_IN_B, S_EXEC, S_CONV, S_DONE, S_ERROR} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t              state_q;
  op_t                 op_q;
  logic [1:0]          status_q;
  logic [W-1:0]        a_q, b_q, res_q, mplier_q, bin_q;
  logic [3:0]          na_q, nb_q;
  logic [CW-1:0]       cnt_q;
  logic [2*W-1:0]      acc_q, mcand_q;
  logic [4*DIGITS-2:0] bcd_q;
  logic [3:0]          disp_q [DIGITS];
  logic [PW-1:0]       pos_q;

  logic key_digit, key_op, key_eq, key_clr;
  op_t  key_opcode;

  always_comb begin
    key_digit = cmd_valid && (cmd <= 4'd9);
    key_eq    = cmd_valid && (cmd == 4'd14);
    key_clr   = cmd_valid && (cmd == 4'd15);
`ifdef CALC_DIV_EN
    key_op    = cmd_valid && (cmd >= 4'd10) && (cmd <= 4'd13);
`else
    key_op    = cmd_valid && (cmd >= 4'd10) && (cmd <= 4'd12);
`endif
    // codes 10..13 map onto ADD..DIV by their low two bits minus two
    key_opcode = op_t'(cmd[1:0] - 2'd2);
  end

  logic [W-1:0] a_digit, b_digit;
  assign a_digit = a_q * W'(10) + W'(cmd);
  assign b_digit = b_q * W'(10) + W'(cmd);

  logic [3:0] disp_shift [DIGITS];
  logic [3:0] disp_fresh [DIGITS];
  logic [3:0] disp_conv  [DIGITS];
  logic [4*DIGITS-1:0] dd_next;
  logic [4*DIGITS-5:0] dd_low_adj;

  assign disp_shift[0] = cmd;
  assign disp_fresh[0] = cmd;
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_shift
    assign disp_shift[gi] = disp_q[gi-1];
    assign disp_fresh[gi] = 4'h0;
  end

  // The top BCD digit never reaches 5 before its last shift, so only the lower digits adjust.
  for (genvar gi = 0; gi < DIGITS-1; gi++) begin : g_dabble
    assign dd_low_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                               : bcd_q[4*gi +: 4];
  end
  assign dd_next = {bcd_q[4*DIGITS-2 -: 3], dd_low_adj, bin_q[W-1]};

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_conv
    assign disp_conv[gi] = dd_next[4*gi +: 4];
  end

  logic [W:0]     sum_w;
  logic [2*W-1:0] acc_next;
  assign sum_w    = {1'b0, a_q} + {1'b0, b_q};
  assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;

`ifdef CALC_DIV_EN
  logic [W-1:0] rem_q, quo_q, rem_next, quo_next;
  logic [W:0]   div_shift;
  logic         div_ge;
  assign div_shift = {rem_q, quo_q[W-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign rem_next  = div_ge ? W'(div_shift - {1'b0, b_q}) : div_shift[W-1:0];
  assign quo_next  = {quo_q[W-2:0], div_ge};
`endif

  logic         exec_last, exec_err;
  logic [W-1:0] exec_val;

  always_comb begin
    exec_last = 1'b1;
    exec_err  = 1'b0;
    exec_val  = '0;
    case (op_q)
      OP_ADD: begin
        exec_err = (sum_w >= LIMIT[W:0]);
        exec_val = sum_w[W-1:0];
      end
      OP_SUB: begin
        exec_err = (a_q < b_q);
        exec_val = a_q - b_q;
      end
      OP_MUL: begin
        exec_last = (cnt_q == CW'(W-1));
        exec_err  = (acc_next >= LIMIT);
        exec_val  = acc_next[W-1:0];
      end
      default: begin
        exec_last = (cnt_q == CW'(W-1));
`ifdef CALC_DIV_EN
        exec_err  = (b_q == '0);
        exec_val  = quo_next;
`else
        exec_err  = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || key_clr) begin
      state_q  <= S_IDLE;
      status_q <= ST_READY;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      na_q     <= '0;
      nb_q     <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      bcd_q    <= '0;
      bin_q    <= '0;
`ifdef CALC_DIV_EN
      rem_q    <= '0;
      quo_q    <= '0;
`endif
      for (int i = 0; i < DIGITS; i++) disp_q[i] <= 4'h0;
    end else begin
      case (state_q)
        S_IDLE: if (key_digit) begin
          a_q     <= W'(cmd);
          na_q    <= 4'd1;
          disp_q  <= disp_shift;
          state_q <= S_IN_A;
        end
        S_IN_A: begin
          if (key_digit) begin
            if (na_q < 4'(DIGITS)) begin
              a_q    <= a_digit;
              na_q   <= na_q + 4'd1;
              disp_q <= disp_shift;
            end
          end else if (key_op) begin
            op_q    <= key_opcode;
            state_q <= S_OP;
            for (int i = 0; i < DIGITS; i++) disp_q[i] <= 4'h0;
          end
        end
        S_OP: begin
          if (key_digit) begin
            b_q     <= W'(cmd);
            nb_q    <= 4'd1;
            disp_q  <= disp_fresh;
            state_q <= S_IN_B;
          end else if (key_op) begin
            op_q <= key_opcode;
          end
        end
        S_IN_B: begin
          if (key_digit) begin
            if (nb_q < 4'(DIGITS)) begin
              b_q    <= b_digit;
              nb_q   <= nb_q + 4'd1;
              disp_q <= disp_shift;
            end
          end else if (key_eq) begin
            state_q  <= S_EXEC;
            status_q <= ST_BUSY;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{W{1'b0}}, a_q};
            mplier_q <= b_q;
`ifdef CALC_DIV_EN
            rem_q    <= '0;
            quo_q    <= a_q;
`endif
          end
        end
        S_EXEC: begin
          cnt_q    <= cnt_q + 1'b1;
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
`ifdef CALC_DIV_EN
          rem_q    <= rem_next;
          quo_q    <= quo_next;
`endif
          if (exec_last) begin
            if (exec_err) begin
              state_q  <= S_ERROR;
              status_q <= ST_ERR;
              for (int i = 0; i < DIGITS; i++) disp_q[i] <= 4'hE;
            end else begin
              state_q <= S_CONV;
              res_q   <= exec_val;
              bin_q   <= exec_val;
              bcd_q   <= '0;
              cnt_q   <= '0;
            end
          end
        end
        S_CONV: begin
          bcd_q <= dd_next[4*DIGITS-2:0];
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W-1)) begin
            disp_q   <= disp_conv;
            state_q  <= S_DONE;
            status_q <= ST_VALID;
          end
        end
        S_DONE: begin
          if (key_op) begin
            a_q      <= res_q;
            na_q     <= 4'(DIGITS);
            op_q     <= key_opcode;
            state_q  <= S_OP;
            status_q <= ST_READY;
          end else if (key_digit) begin
            a_q      <= W'(cmd);
            na_q     <= 4'd1;
            disp_q   <= disp_fresh;
            state_q  <= S_IN_A;
            status_q <= ST_READY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || pos_q == PW'(DIGITS-1)) pos_q <= '0;
    else                                 pos_q <= pos_q + 1'b1;
  end

  assign status   = status_q;
  assign position = pos_q;
  assign data     = disp_q[pos_q];
endmodule

// File: tb/tb_calc_core_n.sv
// Bench for calc_core_n (DIGITS=8): directed keypad sequences and random expressions,
// checked against a key-level decimal calculator model.
module tb_calc_core_n;
  localparam int     DIGITS = 8;
  localparam int     W      = 27;
  localparam longint LIMIT  = 64'd100000000;
`ifdef CALC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic       clock     = 1'b0;
  logic       reset     = 1'b1;
  logic [3:0] cmd       = 4'd0;
  logic       cmd_valid = 1'b0;
  logic [1:0] status;
  logic [3:0] data;
  logic [2:0] position;

  calc_core_n #(.DIGITS(DIGITS)) dut (
    .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .status(status), .data(data), .position(position)
  );

  always #5 clock = ~clock;

  int since_rst = 0;
  always @(posedge clock) since_rst <= reset ? 0 : since_rst + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef enum int {M_IDLE, M_INA, M_OP, M_INB, M_DONE, M_ERR} mstate_t;
  mstate_t m_st;
  longint  m_a, m_b, m_res, m_disp;
  int      m_na, m_nb, m_op, m_busy;
  bit      m_err, m_exec;

  task automatic model_clear();
    m_st = M_IDLE; m_a = 0; m_b = 0; m_res = 0; m_disp = 0;
    m_na = 0; m_nb = 0; m_op = 10; m_err = 0; m_exec = 0; m_busy = 0;
  endtask

  function automatic bit is_op(input int k);
    return (k >= 10 && k <= 12) || (DIV_EN && k == 13);
  endfunction

  task automatic evaluate();
    longint r;
    bit     bad;
    int     lat;
    lat = (m_op >= 12) ? W : 1;
    bad = 0;
    r   = 0;
    case (m_op)
      10: r = m_a + m_b;
      11: begin bad = (m_a < m_b); r = m_a - m_b; end
      12: r = m_a * m_b;
      default: begin bad = (m_b == 0); r = (m_b == 0) ? 0 : m_a / m_b; end
    endcase
    if (!bad && r >= LIMIT) bad = 1;
    m_exec = 1;
    if (bad) begin
      m_st = M_ERR; m_err = 1; m_busy = lat;
    end else begin
      m_st = M_DONE; m_res = r; m_disp = r; m_busy = lat + W;
    end
  endtask

  task automatic mkey(input int k);
    if (k == 15) begin model_clear(); return; end
    case (m_st)
      M_IDLE: if (k <= 9) begin m_a = k; m_na = 1; m_disp = k; m_st = M_INA; end
      M_INA: begin
        if (k <= 9) begin
          if (m_na < DIGITS) begin m_a = m_a * 10 + k; m_na++; m_disp = m_a; end
        end else if (is_op(k)) begin m_op = k; m_disp = 0; m_st = M_OP; end
      end
      M_OP: begin
        if (k <= 9) begin m_b = k; m_nb = 1; m_disp = k; m_st = M_INB; end
        else if (is_op(k)) m_op = k;
      end
      M_INB: begin
        if (k <= 9) begin
          if (m_nb < DIGITS) begin m_b = m_b * 10 + k; m_nb++; m_disp = m_b; end
        end else if (k == 14) evaluate();
      end
      M_DONE: begin
        if (is_op(k)) begin m_a = m_res; m_na = DIGITS; m_op = k; m_st = M_OP; end
        else if (k <= 9) begin m_a = k; m_na = 1; m_disp = k; m_st = M_INA; end
      end
      default: ;
    endcase
  endtask

  function automatic int exp_status();
    if (m_st == M_DONE) return 3;
    if (m_st == M_ERR)  return 2;
    return 0;
  endfunction

  function automatic int exp_digit(input int p);
    longint v;
    if (m_err) return 14;
    v = m_disp;
    for (int i = 0; i < p; i++) v = v / 10;
    return int'(v % 10);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_display(input string tag);
    for (int i = 0; i < DIGITS; i++) begin
      check({tag, ":pos"}, 64'(position), 64'(since_rst % DIGITS));
      check({tag, ":dig"}, 64'(data), 64'(exp_digit(int'(position))));
      check({tag, ":st"}, 64'(status), 64'(exp_status()));
      @(negedge clock);
    end
  endtask

  task automatic press(input int k);
    cmd = 4'(k);
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd = 4'($urandom_range(0, 15));
    mkey(k);
  endtask

  task automatic key(input int k, input string tag);
    int cnt;
    press(k);
    if (m_exec) begin
      m_exec = 0;
      cnt = 0;
      while (status === 2'd1 && cnt < 200) begin cnt++; @(negedge clock); end
      check({tag, ":busy"}, 64'(cnt), 64'(m_busy));
      check_display(tag);
    end
  endtask

  task automatic keys(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "+": key(10, tag);
        "-": key(11, tag);
        "*": key(12, tag);
        "/": key(13, tag);
        "=": key(14, tag);
        "C": key(15, tag);
        default: key(int'(s[i]) - 48, tag);
      endcase
    end
  endtask

  task automatic enter_num(input int n, input string tag);
    for (int i = 0; i < n; i++) key($urandom_range(0, 9), tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    model_clear();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_status", 64'(status), 64'd0);
    check("rst_pos", 64'(position), 64'd0);
    check("rst_data", 64'(data), 64'd0);
    check_display("reset");

    keys("12+34=", "add_46");
    keys("5-9=", "sub_neg");
    keys("C", "clr");
    check_display("after_clear");

    keys("1234*5678=", "mul");
    keys("C99999999*2=", "mul_ovf");
    keys("C", "clr");

`ifdef CALC_DIV_EN
    keys("100/7=", "div");
    keys("C5/0=", "div0");
    keys("C", "clr");
`else
    keys("100/7", "no_div");
    check_display("a_1007");
    keys("=+3=", "no_div_add");
    keys("C", "clr");
`endif

    keys("6*7=", "chain_a");
    keys("+1=", "chain_b");

    keys("C12*34", "mid_clr");
    press(14);
    repeat (5) @(negedge clock);
    check("mid_busy", 64'(status), 64'd1);
    press(15);
    check("mid_clr_st", 64'(status), 64'd0);
    check_display("mid_clr");

    keys("42", "hold");
    cmd = 4'd5;
    repeat (20) @(negedge clock);
    check_display("hold");

    keys("C123456789", "nine");
    check_display("nine");
    keys("+1=", "nine_add");

    keys("C3*4", "mid_rst");
    press(14);
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    check_display("mid_rst");

    for (int it = 0; it < 30; it++) begin
      if (m_st != M_DONE || $urandom_range(0, 2) == 0) begin
        key(15, "rnd");
        enter_num($urandom_range(1, 9), "rnd_a");
      end
      op = $urandom_range(10, DIV_EN ? 13 : 12);
      key(op, "rnd_op");
      if ($urandom_range(0, 3) == 0) begin
        op = $urandom_range(10, 12);
        key(op, "rnd_op2");
      end
      if (op == 12)      enter_num($urandom_range(1, 4), "rnd_b");
      else if (op == 13) enter_num($urandom_range(1, 3), "rnd_b");
      else               enter_num($urandom_range(1, 9), "rnd_b");
      if ($urandom_range(0, 3) == 0) key(10, "rnd_ign");
      key(14, "rnd_eq");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/calc_core_n.md
# calc_core_n

Parametrised successor of the team's 8-digit four-command calculator core. It accepts a stream of 4-bit keypad codes from the input front end with a valid strobe, holds two unsigned decimal operands of up to DIGITS digits, and executes add, subtract and iterative multiply, plus optional restoring divide. It converts the binary result to BCD by sequential double-dabble and result chaining. A continuously scanned BCD buffer drives the existing display controller through data/position.

## Interface
- DIGITS, 8: decimal digits per operand and on the display (2..9).
- Derived: W = $clog2(10**DIGITS) operand width (27 for DIGITS=8); PW = $clog2(DIGITS) position width.
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- cmd  in  4  keypad code: 0–9 digit, 10 plus, 11 minus, 12 multiply, 13 divide, 14 equals, 15 clear.
- cmd_valid  in  1  cmd sampled only when high; one command per high cycle.
- status  out  2  0 ready/entering, 1 busy, 2 error, 3 result valid.
- data  out  4  BCD digit at current position.
- position  out  PW  display digit index; 0 = least significant.

## Operation
- States: IDLE, IN_A, OP, IN_B, EXEC, CONV, DONE, ERROR.
- IDLE: digit → A=cmd, nA=1, IN_A. Other codes are ignored.
- IN_A/IN_B: digit with n<DIGITS → X=X*10+cmd, n++, and buffer shifts left with the new digit at position 0. Digit with n==DIGITS is ignored; it is not an error.
- IN_A: operator → op latched, buffer cleared, OP. Equals ignored.
- OP: digit → B=cmd, nB=1, IN_B. A further operator replaces op.
- IN_B: equals → EXEC. Operator ignored.
- EXEC: plus = 1 cycle. Minus = 1 cycle; A<B → ERROR. Multiply = shift-add over B bits, exactly W cycles, 2W-bit accumulator. Divide = restoring, exactly W cycles, quotient only; B==0 → ERROR at end of EXEC.
- Overflow: result ≥ 10**DIGITS → ERROR, checked at the last EXEC cycle.
- CONV: double-dabble, exactly W cycles, then the buffer is loaded with BCD including leading zeros → DONE.
- DONE: operator → A=result, nA=DIGITS, op latched, OP (chaining). Digit → A=cmd, buffer cleared then digit shifted in, IN_A. Equals ignored.
- ERROR: buffer shows all 4'hE. Only clear is honoured.
- Clear (15): honoured in every state, including EXEC/CONV, which are aborted. Next state is IDLE, operands, counters and buffer are zeroed.
- In EXEC/CONV, all commands other than clear are ignored.
- Scan: position increments every cycle and wraps DIGITS-1 → 0, independent of state. data = buf[position].

## Timing
- Reset values: status=0, data=0, position=0, state IDLE, buffer all 0, operands 0.
- A command with cmd_valid high at edge t affects state/buffer at edge t. The visible effect appears on data/status from t+1.
- Equals at edge t: status=1 for cycles t+1 .. t+L+W, where L = 1 (add/sub) or W (mul/div). status=3 from t+L+W+1.
- Error raised in EXEC: status=2 the cycle after the failing check; CONV is skipped.
- Clear at t: status=0 and buffer zero from t+1.
- Reset mid-operation: identical to power-on reset values at the next cycle.
- Outputs are registered except data, which is a mux of buffer by position register.

## Configuration
- CALC_DIV_EN defined: code 13 is an operator; divider datapath is built; divide by zero → ERROR.
- CALC_DIV_EN undefined: code 13 is ignored in every state, exactly like an unused code; no divider logic.

## Test plan
All scenarios use DIGITS=8, W=27.
- Keys 1,2,+,3,4,= → status 1 for 28 cycles, then 3; position-indexed data reads 00000046.
- Keys 5,-,9,= → status 2 two cycles after equals; buffer all E. Then 15 → status 0, buffer zero.
- Keys 1,2,3,4,*,5,6,7,8,= → busy 54 cycles → 07006652. Keys 9 ×8,*,2,= → error on overflow.
- With CALC_DIV_EN: keys 1,0,0,/,7,= → 00000014 after 54 busy cycles; keys 5,/,0,= → error. Without the macro: keys 1,0,0,/,7 → A becomes 1007.
- Keys 6,*,7,=, wait for DONE, then +,1,= → 00000043. Clear issued mid-multiply → status 0 next cycle.
- Hold cmd_valid low with cmd=5 for 20 cycles → no state change; position sequence 0..7,0 repeats with period 8. Nine digits entered → only the first 8 are kept.
